packet_builder: RTL

//   Transmit end of the sequenced-stream packet link: serialises one payload of
//   1..37 bytes into the 32-bit word stream consumed by the packet parser.

---
 rtl/packet_builder_if.sv | 25 ++
 rtl/packet_builder.sv | 132 +++++++++++++
 2 files changed

// File: rtl/packet_builder_if.sv
// Payload-in / word-stream-out bundle for the packet builder.
// The master modport is the builder's view; slave is the producer/consumer side.
interface packet_builder_if;
  logic [295:0] payload;
  logic [5:0]   payloadLen;
  logic [15:0]  streamId;
  logic         seqSkip;
  logic         payload_val;
  logic         payload_ready;
  logic         lenError;
  logic [31:0]  dataOut;
  logic         dataOut_val;
  logic         dataOut_last;
  logic         dataOut_ready;

  modport master (
    input  payload, payloadLen, streamId, seqSkip, payload_val, dataOut_ready,
    output payload_ready, lenError, dataOut, dataOut_val, dataOut_last
  );

  modport slave (
    output payload, payloadLen, streamId, seqSkip, payload_val, dataOut_ready,
    input  payload_ready, lenError, dataOut, dataOut_val, dataOut_last
  );
endinterface

// File: rtl/packet_builder.sv
// Packet builder: serialises one 1..37 byte payload into a header word,
// a per-stream sequence word and big-endian payload words, last flag on the
// final word. One 32-bit sequence counter per stream (indexed by streamId LSBs).
module packet_builder #(
  parameter int NUM_STREAMS = 32,
  parameter int MAX_BYTES   = 37
) (
  input  logic              clk,
  input  logic              reset_b,
  packet_builder_if.master  bus
);

  localparam int IDX_W  = $clog2(NUM_STREAMS);
  localparam int PAY_W  = MAX_BYTES * 8;
  localparam int NWORDS = (MAX_BYTES + 3) / 4;
  localparam int BUF_W  = NWORDS * 32;
  localparam int PAD_W  = BUF_W - PAY_W;
  localparam int REM_W  = $clog2(NWORDS + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SEND_HDR  = 2'd1;
  localparam logic [1:0] SEND_SEQ  = 2'd2;
  localparam logic [1:0] SEND_DATA = 2'd3;

  logic [1:0]       state;
  logic [BUF_W-1:0] buf_q;
  logic [BUF_W-1:0] masked;
  logic [31:0]      seq_q;
  logic [31:0]      next_seq;
  logic [31:0]      cnt [NUM_STREAMS];
  logic [REM_W-1:0] rem;
  logic [REM_W-1:0] nwords;
  logic [IDX_W-1:0] sid_idx;
  logic             len_ok;
  logic             accept;
  logic             fire;

  assign sid_idx  = bus.streamId[IDX_W-1:0];
  assign len_ok   = (bus.payloadLen != 6'd0) && (bus.payloadLen <= 6'(MAX_BYTES));
  assign accept   = (state == IDLE) && bus.payload_val && len_ok;
  assign next_seq = cnt[sid_idx] + (bus.seqSkip ? 32'd2 : 32'd1);
  assign nwords   = REM_W'((7'(bus.payloadLen) + 7'd3) >> 2);
  assign fire     = bus.dataOut_val && bus.dataOut_ready;

  // payload_ready is a pure state decode, so it never depends on dataOut_ready
  assign bus.payload_ready = (state == IDLE);

  // Left-align the payload in a whole number of words and zero bytes past the length
  always_comb begin
    masked = {bus.payload, {PAD_W{1'b0}}};
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i >= int'(bus.payloadLen)) masked[BUF_W-1-8*i -: 8] = 8'h00;
    end
  end

  // Per-stream sequence counters advance at acceptance; aliased ids share one
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < NUM_STREAMS; i++) cnt[i] <= '0;
    end else if (accept) begin
      cnt[sid_idx] <= next_seq;
    end
  end

  // Payload shift buffer and captured sequence number (data only, no reset)
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_q <= masked;
      seq_q <= next_seq;
    end else if (fire && (state == SEND_SEQ || state == SEND_DATA)) begin
      buf_q <= buf_q << 32;
    end
  end

  // Packet FSM and registered output word; output only advances on a transfer
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state            <= IDLE;
      rem              <= '0;
      bus.dataOut      <= '0;
      bus.dataOut_val  <= 1'b0;
      bus.dataOut_last <= 1'b0;
      bus.lenError     <= 1'b0;
    end else begin
      bus.lenError <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.payload_val) begin
            if (len_ok) begin
              bus.dataOut      <= {16'(bus.payloadLen) + 16'd8, bus.streamId};
              bus.dataOut_val  <= 1'b1;
              bus.dataOut_last <= 1'b0;
              rem              <= nwords;
              state            <= SEND_HDR;
            end else begin
              bus.lenError <= 1'b1;
            end
          end
        end
        SEND_HDR: begin
          if (fire) begin
            bus.dataOut <= seq_q;
            state       <= SEND_SEQ;
          end
        end
        SEND_SEQ: begin
          if (fire) begin
            bus.dataOut      <= buf_q[BUF_W-1 -: 32];
            bus.dataOut_last <= (rem == REM_W'(1));
            rem              <= rem - REM_W'(1);
            state            <= SEND_DATA;
          end
        end
        default: begin
          if (fire) begin
            if (bus.dataOut_last) begin
              bus.dataOut      <= '0;
              bus.dataOut_val  <= 1'b0;
              bus.dataOut_last <= 1'b0;
              state            <= IDLE;
            end else begin
              bus.dataOut      <= buf_q[BUF_W-1 -: 32];
              bus.dataOut_last <= (rem == REM_W'(1));
              rem              <= rem - REM_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule
